// File: rtl/reg_file_sb_pkg.sv
// ----------------------------------------------------------------------------
// reg_file_sb_pkg
// Shared declarations for the register file with scoreboard:
//   - dump_state_e : states of the debug dump scanner (IDLE, SCAN)
//   - addr_w_of()  : address width needed to index a given register count
//   - pend_max_of(): saturation value of a pending-write counter of given width
// ----------------------------------------------------------------------------
package reg_file_sb_pkg;

    typedef enum logic [0:0] {
        DUMP_IDLE = 1'b0,
        DUMP_SCAN = 1'b1
    } dump_state_e;

    // A single-entry file still needs one address bit to keep vectors legal.
    function automatic int unsigned addr_w_of(input int unsigned num_regs);
        int unsigned w;
        if (num_regs > 32'd1) begin
            w = $clog2(num_regs);
        end else begin
            w = 32'd1;
        end
        return w;
    endfunction

    function automatic int unsigned pend_max_of(input int unsigned pend_w);
        return (32'd1 << pend_w) - 32'd1;
    endfunction

endpackage

// File: rtl/reg_pend_ctr.sv
// ----------------------------------------------------------------------------
// reg_pend_ctr
// Saturating up/down counter tracking outstanding writes to one register.
//   clk, rst : clock, synchronous active-high reset (count -> 0)
//   inc      : accepted reservation for this register
//   dec      : write-back to this register
//   cnt      : current number of outstanding writes
// inc and dec together leave the count unchanged. The counter never wraps:
// a dec at zero and an inc at all-ones both hold.
// ----------------------------------------------------------------------------
module reg_pend_ctr
    import reg_file_sb_pkg::*;
#(
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    output logic [PEND_W-1:0] cnt
);

    localparam logic [PEND_W-1:0] CNT_MAX  = PEND_W'(pend_max_of(PEND_W));
    localparam logic [PEND_W-1:0] CNT_ZERO = {PEND_W{1'b0}};
    localparam logic [PEND_W-1:0] CNT_ONE  = PEND_W'(1'b1);

    logic [PEND_W-1:0] cnt_r;
    logic [PEND_W-1:0] cnt_nx_s;

    // Next count: inc-only counts up, dec-only counts down, both or neither hold.
    always_comb begin
        cnt_nx_s = cnt_r;
        case ({inc, dec})
            2'b10: begin
                if (cnt_r != CNT_MAX) begin
                    cnt_nx_s = cnt_r + CNT_ONE;
                end else begin
                    cnt_nx_s = cnt_r;
                end
            end
            2'b01: begin
                if (cnt_r != CNT_ZERO) begin
                    cnt_nx_s = cnt_r - CNT_ONE;
                end else begin
                    cnt_nx_s = cnt_r;
                end
            end
            default: cnt_nx_s = cnt_r;
        endcase
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_nx_s;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/reg_file_sb.sv
// ----------------------------------------------------------------------------
// reg_file_sb
// Decode-stage register file with per-register pending-write scoreboard and
// a handshaked debug dump port.
//   clk, rst               : clock, synchronous active-high reset
//   rd_addr1/2, src_vld1/2 : source addresses and "source is used" qualifiers
//   rd_data1/2             : source data, write-back bypassed (combinational)
//   rsv_en/rsv_addr/rsv_rdy: destination reservation at issue; rsv_rdy low
//                            means the reservation was dropped and must be held
//   wb_en/wb_addr/wb_data  : write-back port
//   hazard                 : a used source still waits on a pending write
//   dump_start             : begin a full-state scan
//   dump_valid/ready/addr/data/done : scan output stream, done pulses once
//                            in the cycle after the last word is accepted
// ----------------------------------------------------------------------------
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = addr_w_of(NUM_REGS),
    parameter int PEND_W   = 2,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    input  logic              src_vld1,
    input  logic              src_vld2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_rdy,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              hazard,
    input  logic              dump_start,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_done
);

    localparam logic [PEND_W-1:0] CNT_FULL  = PEND_W'(pend_max_of(PEND_W));
    localparam logic [PEND_W-1:0] CNT_ZERO  = {PEND_W{1'b0}};
    localparam logic [PEND_W-1:0] CNT_ONE   = PEND_W'(1'b1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1'b1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    logic [DATA_W-1:0] regs_r [NUM_REGS];
    logic [PEND_W-1:0] cnt_s  [NUM_REGS];
    logic [NUM_REGS-1:0] inc_s;
    logic [NUM_REGS-1:0] dec_s;
    logic              wb_we_s;

    dump_state_e       state_r;
    dump_state_e       state_nx_s;
    logic              dump_valid_r;
    logic              dump_valid_nx_s;
    logic              dump_done_r;
    logic              dump_done_nx_s;
    logic [ADDR_W-1:0] dump_addr_r;
    logic [ADDR_W-1:0] dump_addr_nx_s;
    logic [DATA_W-1:0] dump_data_r;
    logic [DATA_W-1:0] dump_data_nx_s;
    logic [ADDR_W-1:0] fetch_addr_s;
    logic [DATA_W-1:0] fetch_data_s;

    // Architectural value of one register as seen this cycle: hardwired zero,
    // then an in-flight write-back, then storage.
    function automatic logic [DATA_W-1:0] byp_read(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              we,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata
    );
        logic [DATA_W-1:0] val;
        if (ZERO_REG && (addr == ADDR_ZERO)) begin
            val = {DATA_W{1'b0}};
        end else if (we && (waddr == addr)) begin
            val = wdata;
        end else begin
            val = stored;
        end
        return val;
    endfunction

    // A source blocks if writes remain pending after any write-back this
    // cycle retires one of them.
    function automatic logic src_blocked(
        input logic              vld,
        input logic [PEND_W-1:0] cnt,
        input logic              wb_hit
    );
        logic blk;
        if (!vld) begin
            blk = 1'b0;
        end else if (wb_hit) begin
            blk = (cnt > CNT_ONE);
        end else begin
            blk = (cnt != CNT_ZERO);
        end
        return blk;
    endfunction

    assign wb_we_s = wb_en & ~(ZERO_REG & (wb_addr == ADDR_ZERO));

    // Storage: reset to the index pattern, then written by write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= DATA_W'(i);
            end
        end else if (wb_we_s) begin
            regs_r[wb_addr] <= wb_data;
        end else begin
            regs_r <= regs_r;
        end
    end

    assign rd_data1 = byp_read(rd_addr1, regs_r[rd_addr1], wb_we_s, wb_addr, wb_data);
    assign rd_data2 = byp_read(rd_addr2, regs_r[rd_addr2], wb_we_s, wb_addr, wb_data);

    // rsv_rdy looks only at the stored count: a full counter refuses a new
    // reservation even if a write-back to it lands in the same cycle.
    assign rsv_rdy = ~rsv_en | (cnt_s[rsv_addr] != CNT_FULL);

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_ctr
        localparam bit COUNTED = !(ZERO_REG && (g == 0));
        assign inc_s[g] = COUNTED && rsv_en && rsv_rdy && (rsv_addr == ADDR_W'(g));
        assign dec_s[g] = COUNTED && wb_en && (wb_addr == ADDR_W'(g));

        reg_pend_ctr #(
            .PEND_W (PEND_W)
        ) u_ctr (
            .clk (clk),
            .rst (rst),
            .inc (inc_s[g]),
            .dec (dec_s[g]),
            .cnt (cnt_s[g])
        );
    end

    // The same-cycle reservation is not part of cnt_s yet, so an instruction
    // never stalls on its own destination.
    assign hazard = src_blocked(src_vld1, cnt_s[rd_addr1], dec_s[rd_addr1])
                  | src_blocked(src_vld2, cnt_s[rd_addr2], dec_s[rd_addr2]);

    // Address of the word the scanner would latch next: 0 when starting,
    // otherwise the one after the word currently presented.
    always_comb begin
        if (state_r == DUMP_SCAN) begin
            fetch_addr_s = dump_addr_r + ADDR_ONE;
        end else begin
            fetch_addr_s = ADDR_ZERO;
        end
    end

    assign fetch_data_s = byp_read(fetch_addr_s, regs_r[fetch_addr_s], wb_we_s, wb_addr, wb_data);

    // Dump scanner next state; the presented word is a snapshot and only
    // changes on a handshake.
    always_comb begin
        state_nx_s      = state_r;
        dump_addr_nx_s  = dump_addr_r;
        dump_data_nx_s  = dump_data_r;
        dump_valid_nx_s = dump_valid_r;
        dump_done_nx_s  = 1'b0;
        case (state_r)
            DUMP_IDLE: begin
                if (dump_start) begin
                    state_nx_s      = DUMP_SCAN;
                    dump_addr_nx_s  = ADDR_ZERO;
                    dump_data_nx_s  = fetch_data_s;
                    dump_valid_nx_s = 1'b1;
                end else begin
                    dump_valid_nx_s = 1'b0;
                end
            end
            DUMP_SCAN: begin
                if (dump_valid_r && dump_ready) begin
                    if (dump_addr_r == LAST_ADDR) begin
                        state_nx_s      = DUMP_IDLE;
                        dump_valid_nx_s = 1'b0;
                        dump_done_nx_s  = 1'b1;
                    end else begin
                        dump_addr_nx_s = fetch_addr_s;
                        dump_data_nx_s = fetch_data_s;
                    end
                end else begin
                    state_nx_s = DUMP_SCAN;
                end
            end
            default: begin
                state_nx_s      = DUMP_IDLE;
                dump_valid_nx_s = 1'b0;
            end
        endcase
    end

    // Dump scanner registers; all outputs of the port are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= DUMP_IDLE;
            dump_addr_r  <= ADDR_ZERO;
            dump_data_r  <= {DATA_W{1'b0}};
            dump_valid_r <= 1'b0;
            dump_done_r  <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            dump_addr_r  <= dump_addr_nx_s;
            dump_data_r  <= dump_data_nx_s;
            dump_valid_r <= dump_valid_nx_s;
            dump_done_r  <= dump_done_nx_s;
        end
    end

    assign dump_valid = dump_valid_r;
    assign dump_done  = dump_done_r;
    assign dump_addr  = dump_addr_r;
    assign dump_data  = dump_data_r;

endmodule

// File: tb/tb_reg_file_sb.sv
// ----------------------------------------------------------------------------
// tb_reg_file_sb
// Bench for reg_file_sb (default parameters): table of read/reserve/write-back
// vectors with hand-derived expectations, plus dump sequences whose words are
// queued from a reference register model and compared at each handshake.
// ----------------------------------------------------------------------------
module tb_reg_file_sb;

    logic        clk;
    logic        rst;
    logic [3:0]  rd_addr1, rd_addr2;
    logic        src_vld1, src_vld2;
    logic [31:0] rd_data1, rd_data2;
    logic        rsv_en;
    logic [3:0]  rsv_addr;
    logic        rsv_rdy;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        hazard;
    logic        dump_start;
    logic        dump_valid;
    logic        dump_ready;
    logic [3:0]  dump_addr;
    logic [31:0] dump_data;
    logic        dump_done;

    reg_file_sb dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .src_vld1   (src_vld1),
        .src_vld2   (src_vld2),
        .rd_data1   (rd_data1),
        .rd_data2   (rd_data2),
        .rsv_en     (rsv_en),
        .rsv_addr   (rsv_addr),
        .rsv_rdy    (rsv_rdy),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .hazard     (hazard),
        .dump_start (dump_start),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .dump_done  (dump_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  a1, a2;
        logic        v1, v2, re;
        logic [3:0]  ra;
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd, e1, e2;
        logic        ehz, erdy;
    } vec_t;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
    } dump_exp_t;

    dump_exp_t   exp_q[$];
    logic [31:0] m_regs [16];
    int          n_cmp, n_err;
    int          cyc_cnt, last_hs_cyc, done_seen, done_cyc, start_cyc;

    function automatic vec_t mk(input logic [3:0] a1, a2, input logic v1, v2, re,
                                input logic [3:0] ra, input logic we, input logic [3:0] wa,
                                input logic [31:0] wd, e1, e2, input logic ehz, erdy);
        vec_t v;
        v.a1 = a1; v.a2 = a2; v.v1 = v1; v.v2 = v2; v.re = re; v.ra = ra;
        v.we = we; v.wa = wa; v.wd = wd; v.e1 = e1; v.e2 = e2; v.ehz = ehz; v.erdy = erdy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    // Scoreboard side: pop one expected word per handshake, note dump_done.
    task automatic mon();
        dump_exp_t e;
        if (dump_valid && dump_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL dump_extra: got word addr %h data %h, expected none", dump_addr, dump_data);
            end else begin
                e = exp_q.pop_front();
                chk("dump_addr", 32'(dump_addr), 32'(e.addr));
                chk("dump_data", dump_data, e.data);
            end
            last_hs_cyc = cyc_cnt;
        end
        if (dump_done) begin
            done_seen++;
            done_cyc = cyc_cnt;
        end
    endtask

    task automatic finish_cycle();
        mon();
        @(posedge clk);
        #1;
        cyc_cnt++;
    endtask

    task automatic tick();
        @(negedge clk);
        finish_cycle();
    endtask

    task automatic idle_inputs();
        rd_addr1 = 4'd0; rd_addr2 = 4'd0; src_vld1 = 1'b0; src_vld2 = 1'b0;
        rsv_en = 1'b0; rsv_addr = 4'd0; wb_en = 1'b0; wb_addr = 4'd0; wb_data = 32'd0;
        dump_start = 1'b0; dump_ready = 1'b0;
    endtask

    task automatic push_all();
        dump_exp_t e;
        for (int i = 0; i < 16; i++) begin
            e.addr = 4'(i);
            e.data = m_regs[i];
            exp_q.push_back(e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [23];
        logic hit;
        bit   wrote;
        bit   found;

        n_cmp = 0; n_err = 0; cyc_cnt = 0; last_hs_cyc = -10; done_seen = 0; done_cyc = -10;
        for (int i = 0; i < 16; i++) m_regs[i] = 32'(i);
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // ---------------- reset state ----------------
        rd_addr1 = 4'd5; rd_addr2 = 4'd15; src_vld1 = 1'b1; src_vld2 = 1'b1; #1;
        chk("rst_dump_valid", 32'(dump_valid), 32'd0);
        chk("rst_dump_done", 32'(dump_done), 32'd0);
        chk("rst_dump_addr", 32'(dump_addr), 32'd0);
        chk("rst_dump_data", dump_data, 32'd0);
        chk("rst_hazard", 32'(hazard), 32'd0);
        chk("rst_rd1", rd_data1, 32'd5);
        chk("rst_rd2", rd_data2, 32'd15);
        idle_inputs();

        // ---------------- dump 1: ready tied high ----------------
        push_all();
        dump_ready = 1'b1; dump_start = 1'b1;
        start_cyc = cyc_cnt;
        tick();
        dump_start = 1'b0;
        chk("dump1_first_valid", 32'(dump_valid), 32'd1);
        chk("dump1_first_addr", 32'(dump_addr), 32'd0);
        done_seen = 0;
        for (int k = 0; k < 40 && done_seen == 0; k++) tick();
        chk("dump1_done_seen", 32'(done_seen), 32'd1);
        chk("dump1_done_after_last", 32'(done_cyc), 32'(last_hs_cyc + 1));
        chk("dump1_duration", 32'(done_cyc), 32'(start_cyc + 17));
        chk("dump1_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("dump1_done_pulse", 32'(dump_done), 32'd0);
        chk("dump1_valid_low", 32'(dump_valid), 32'd0);
        dump_ready = 1'b0;

        // ---------------- table: reads, bypass, scoreboard ----------------
        tbl[0]  = mk(4'd3, 4'd4,  1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0,        32'd3,        32'd4,        1'b0, 1'b1);
        tbl[1]  = mk(4'd3, 4'd3,  1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd3, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b1);
        tbl[2]  = mk(4'd3, 4'd15, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0,        32'hDEADBEEF, 32'd15,       1'b0, 1'b1);
        tbl[3]  = mk(4'd5, 4'd4,  1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 4'd0, 32'd0,        32'd5,        32'd4,        1'b0, 1'b1);
        tbl[4]  = mk(4'd5, 4'd4,  1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 4'd0, 32'd0,        32'd5,        32'd4,        1'b1, 1'b1);
        tbl[5]  = mk(4'd5, 4'd4,  1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd5, 32'h55,       32'h55,       32'd4,        1'b1, 1'b1);
        tbl[6]  = mk(4'd5, 4'd5,  1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 4'd5, 32'h66,       32'h66,       32'h66,       1'b0, 1'b1);
        tbl[7]  = mk(4'd5, 4'd4,  1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0,        32'h66,       32'd4,        1'b0, 1'b1);
        tbl[8]  = mk(4'd9, 4'd4,  1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd9, 32'h1234,     32'h1234,     32'd4,        1'b0, 1'b1);
        tbl[9]  = mk(4'd7, 4'd4,  1'b0, 1'b0, 1'b1, 4'd7, 1'b0, 4'd0, 32'd0,        32'd7,        32'd4,        1'b0, 1'b1);
        tbl[10] = mk(4'd7, 4'd4,  1'b1, 1'b0, 1'b1, 4'd7, 1'b0, 4'd0, 32'd0,        32'd7,        32'd4,        1'b1, 1'b1);
        tbl[11] = mk(4'd7, 4'd4,  1'b0, 1'b0, 1'b1, 4'd7, 1'b0, 4'd0, 32'd0,        32'd7,        32'd4,        1'b0, 1'b1);
        tbl[12] = mk(4'd4, 4'd7,  1'b0, 1'b1, 1'b1, 4'd7, 1'b0, 4'd0, 32'd0,        32'd4,        32'd7,        1'b1, 1'b0);
        tbl[13] = mk(4'd7, 4'd4,  1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd7, 32'h70,       32'h70,       32'd4,        1'b1, 1'b1);
        tbl[14] = mk(4'd7, 4'd4,  1'b1, 1'b0, 1'b1, 4'd7, 1'b1, 4'd7, 32'h71,       32'h71,       32'd4,        1'b1, 1'b1);
        tbl[15] = mk(4'd7, 4'd4,  1'b1, 1'b0, 1'b1, 4'd7, 1'b0, 4'd0, 32'd0,        32'h71,       32'd4,        1'b1, 1'b1);
        tbl[16] = mk(4'd7, 4'd4,  1'b1, 1'b0, 1'b1, 4'd7, 1'b0, 4'd0, 32'd0,        32'h71,       32'd4,        1'b1, 1'b0);
        tbl[17] = mk(4'd7, 4'd4,  1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd7, 32'h80,       32'h80,       32'd4,        1'b1, 1'b1);
        tbl[18] = mk(4'd7, 4'd4,  1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd7, 32'h81,       32'h81,       32'd4,        1'b1, 1'b1);
        tbl[19] = mk(4'd7, 4'd4,  1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd7, 32'h82,       32'h82,       32'd4,        1'b0, 1'b1);
        tbl[20] = mk(4'd7, 4'd4,  1'b1, 1'b0, 1'b1, 4'd7, 1'b0, 4'd0, 32'd0,        32'h82,       32'd4,        1'b0, 1'b1);
        tbl[21] = mk(4'd7, 4'd4,  1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd7, 32'h90,       32'h90,       32'd4,        1'b0, 1'b1);
        tbl[22] = mk(4'd2, 4'd4,  1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0,        32'd2,        32'd4,        1'b0, 1'b1);

        for (int i = 0; i < 23; i++) begin
            rd_addr1 = tbl[i].a1; rd_addr2 = tbl[i].a2;
            src_vld1 = tbl[i].v1; src_vld2 = tbl[i].v2;
            rsv_en = tbl[i].re; rsv_addr = tbl[i].ra;
            wb_en = tbl[i].we; wb_addr = tbl[i].wa; wb_data = tbl[i].wd;
            @(negedge clk);
            chk($sformatf("v%0d_rd1", i), rd_data1, tbl[i].e1);
            chk($sformatf("v%0d_rd2", i), rd_data2, tbl[i].e2);
            chk($sformatf("v%0d_hazard", i), 32'(hazard), 32'(tbl[i].ehz));
            chk($sformatf("v%0d_rsv_rdy", i), 32'(rsv_rdy), 32'(tbl[i].erdy));
            finish_cycle();
            if (tbl[i].we) m_regs[tbl[i].wa] = tbl[i].wd;
        end
        idle_inputs();

        // ---------------- dump 2: ready toggling, write while stalled ----------------
        push_all();
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        wrote = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 100 && done_seen == 0; k++) begin
            dump_ready = k[0];
            dump_start = (k == 6);
            hit = dump_valid && (dump_addr == 4'd9) && !dump_ready && !wrote;
            wb_en = hit; wb_addr = 4'd9; wb_data = 32'hAAAA5555;
            @(negedge clk);
            if (hit) chk("dump2_snapshot_hold", dump_data, 32'h1234);
            finish_cycle();
            if (hit) begin
                wrote = 1'b1;
                m_regs[9] = 32'hAAAA5555;
            end
        end
        wb_en = 1'b0; dump_start = 1'b0; dump_ready = 1'b1;
        chk("dump2_write_hit", 32'(wrote), 32'd1);
        chk("dump2_done_seen", 32'(done_seen), 32'd1);
        chk("dump2_done_after_last", 32'(done_cyc), 32'(last_hs_cyc + 1));
        chk("dump2_queue_empty", 32'(exp_q.size()), 32'd0);
        tick();
        chk("dump2_no_restart", 32'(dump_valid), 32'd0);
        rd_addr1 = 4'd9; #1;
        chk("dump2_r9_written", rd_data1, m_regs[9]);
        idle_inputs();

        // ---------------- reset in the middle of a scan ----------------
        rsv_en = 1'b1; rsv_addr = 4'd2; tick(); tick();
        rsv_addr = 4'd11; tick();
        rsv_en = 1'b0;
        rd_addr1 = 4'd2; rd_addr2 = 4'd11; src_vld1 = 1'b1; src_vld2 = 1'b0; #1;
        chk("pre_rst_hazard_r2", 32'(hazard), 32'd1);
        src_vld1 = 1'b0;
        push_all();
        dump_ready = 1'b1; dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        found = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (dump_valid && dump_addr == 4'd6) found = 1'b1;
            else tick();
        end
        chk("rst_mid_reached_addr6", 32'(found), 32'd1);
        dump_ready = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        chk("rst_mid_valid", 32'(dump_valid), 32'd0);
        chk("rst_mid_addr", 32'(dump_addr), 32'd0);
        chk("rst_mid_data", dump_data, 32'd0);
        chk("rst_mid_done", 32'(dump_done), 32'd0);
        src_vld1 = 1'b1; src_vld2 = 1'b1; #1;
        chk("rst_mid_hazard", 32'(hazard), 32'd0);
        src_vld1 = 1'b0; src_vld2 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rd_addr1 = 4'(i); #1;
            chk($sformatf("rst_mid_reg%0d", i), rd_data1, 32'(i));
        end
        tick(); tick(); tick();
        chk("rst_mid_no_done", 32'(done_seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
